nw_output_vc_credit_status: RTL

- Upstream-side credit and status tracker for every output VC of a router.
- Per output port and VC it counts downstream buffer credits and tracks whether the VC is free or allocated.
- From these it drives the per-output-VC blocked/ready status vector and the per-port free-VC-blocked flags that the input-side VC blocked-status logic consumes.
- Sits between switch traversal and credit return at the output ports, and the VC/switch allocators at the inputs.

---
 rtl/nw_output_vc_credit_status_pkg.sv | 21 ++
 rtl/nw_output_vc_credit_status_credit_counter.sv | 82 ++++++++
 rtl/nw_output_vc_credit_status.sv | 66 ++++++
 3 files changed

// File: rtl/nw_output_vc_credit_status_pkg.sv
// Shared types and helpers for output-VC credit/status tracking and the VC allocators.
package nw_output_vc_credit_status_pkg;

    localparam int NP      = 5;
    localparam int NV      = 4;
    localparam int BUF_LEN = 4;
    localparam int CW      = $clog2(BUF_LEN + 1);

    typedef logic [CW-1:0] credit_t;

    typedef enum logic {
        VC_FREE  = 1'b0,
        VC_ALLOC = 1'b1
    } vc_state_e;

    // Isolates the lowest set bit; the same fixed priority the allocators use for free VCs.
    function automatic logic [NV-1:0] lowest_set_onehot(input logic [NV-1:0] req);
        return req & (~req + NV'(1));
    endfunction

endpackage

// File: rtl/nw_output_vc_credit_status_credit_counter.sv
// One output VC: saturating credit counter, registered blocked status and FREE/ALLOC state.
module nw_vc_credit_counter
    import nw_output_vc_credit_status_pkg::*;
#(
    parameter int  buf_len = BUF_LEN,
    localparam int cw      = $clog2(buf_len + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flit_sent_i,
    input  logic          tail_sent_i,
    input  logic          credit_in_i,
    input  logic          vc_alloc_i,
    output logic [cw-1:0] count_o,
    output logic          status_o,
    output logic          free_o,
    output logic          err_o
);

    localparam logic [cw-1:0] FULL = cw'(buf_len);

    logic [cw-1:0] count_q, count_d;
    logic          status_q;
    logic          cnt_err;
    logic          fsm_err;
    logic          release_w;
    vc_state_e     state_q, state_d;

    assign release_w = flit_sent_i & tail_sent_i;

    always_comb begin
        count_d = count_q;
        cnt_err = 1'b0;
        case ({flit_sent_i, credit_in_i})
            2'b10: begin
                if (count_q == '0) cnt_err = 1'b1;
                else               count_d = count_q - 1'b1;
            end
            2'b01: begin
                if (count_q == FULL) cnt_err = 1'b1;
                else                 count_d = count_q + 1'b1;
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= FULL;
            status_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            status_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= VC_FREE;
        else     state_q <= state_d;
    end

    // A tail leaving in the same cycle as a new claim is back-to-back reuse: stay allocated.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VC_FREE:  if (vc_alloc_i) state_d = VC_ALLOC;
            VC_ALLOC: if (release_w && !vc_alloc_i) state_d = VC_FREE;
            default:  state_d = VC_FREE;
        endcase
    end

    always_comb begin
        free_o  = (state_q == VC_FREE);
        fsm_err = ((state_q == VC_FREE) && flit_sent_i)
                | ((state_q == VC_ALLOC) && vc_alloc_i && !release_w);
    end

    assign count_o  = count_q;
    assign status_o = status_q;
    assign err_o    = cnt_err | fsm_err;

endmodule

// File: rtl/nw_output_vc_credit_status.sv
// Credit and free/allocated tracking for every output VC, plus per-port free-VC blocked flags.
module nw_output_vc_credit_status
    import nw_output_vc_credit_status_pkg::*;
#(
    parameter int  np      = NP,
    parameter int  nv      = NV,
    parameter int  buf_len = BUF_LEN,
    localparam int cw      = $clog2(buf_len + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [np-1:0][nv-1:0]  flit_sent,
    input  logic [np-1:0][nv-1:0]  tail_sent,
    input  logic [np-1:0][nv-1:0]  credit_in,
    input  logic [np-1:0][nv-1:0]  vc_alloc,
    output logic [np-1:0][nv-1:0]  vc_status,
    output logic [np-1:0][nv-1:0]  vc_free,
    output logic [np-1:0]          free_vc_blocked,
    output logic [np-1:0]          error
);

    logic [cw-1:0]         count_w [np][nv];
    logic [np-1:0][nv-1:0] zero_cnt;
    logic [np-1:0][nv-1:0] err_pulse;
    logic [np-1:0][nv-1:0] cand_sel;
    logic [np-1:0]         error_q, error_d;

    for (genvar p = 0; p < np; p++) begin : g_port
        for (genvar v = 0; v < nv; v++) begin : g_vc
            nw_vc_credit_counter #(
                .buf_len (buf_len)
            ) u_cnt (
                .clk         (clk),
                .rst         (rst),
                .flit_sent_i (flit_sent[p][v]),
                .tail_sent_i (tail_sent[p][v]),
                .credit_in_i (credit_in[p][v]),
                .vc_alloc_i  (vc_alloc[p][v]),
                .count_o     (count_w[p][v]),
                .status_o    (vc_status[p][v]),
                .free_o      (vc_free[p][v]),
                .err_o       (err_pulse[p][v])
            );
            assign zero_cnt[p][v] = (count_w[p][v] == '0);
        end

        // Blocked when no VC is free or the allocator's pick has no credit left.
        assign cand_sel[p]        = lowest_set_onehot(vc_free[p]);
        assign free_vc_blocked[p] = (cand_sel[p] == '0) | (|(cand_sel[p] & zero_cnt[p]));
    end

    always_comb begin
        error_d = error_q;
        for (int p = 0; p < np; p++) begin
            error_d[p] = error_q[p] | (|err_pulse[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) error_q <= '0;
        else     error_q <= error_d;
    end

    assign error = error_q;

endmodule
